// File: rtl/spi_master.sv
// SPI mode-0 master: shifts an operand word out on MOSI, waits for the slave's
// ready flag (bounded by a timeout), then shifts a result word in from MISO.
module spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned TX_BITS = 16,
  parameter int unsigned RX_BITS = 18,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               hz100,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TX_BITS-1:0] operands,
  output logic               spi_clk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [RX_BITS-1:0] result
);
  localparam int unsigned CNT_MAX = (TIMEOUT > CLK_DIV) ? TIMEOUT : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_MAX = (TX_BITS > RX_BITS) ? TX_BITS : RX_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(TIMEOUT - 1);
  localparam logic [BIT_W-1:0] TX_LAST  = BIT_W'(TX_BITS - 1);
  localparam logic [BIT_W-1:0] RX_LAST  = BIT_W'(RX_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, TX, WAIT_RDY, RX, FINISH} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [TX_BITS-1:0] tx_sr, tx_sr_nx;
  logic [RX_BITS-1:0] rx_sr, rx_sr_nx, result_nx;
  logic               spi_clk_nx, cs_nx, mosi_nx, done_nx, timeout_nx;
  logic               ready_meta, ready_sync;
  logic               half_end;

  always_ff @(posedge hz100 or negedge rst_n) begin
    if (!rst_n) begin
      ready_meta <= 1'b0;
      ready_sync <= 1'b0;
    end else begin
      ready_meta <= ready;
      ready_sync <= ready_meta;
    end
  end

  always_ff @(posedge hz100 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      result  <= '0;
      spi_clk <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      tx_sr   <= tx_sr_nx;
      rx_sr   <= rx_sr_nx;
      result  <= result_nx;
      spi_clk <= spi_clk_nx;
      cs      <= cs_nx;
      mosi    <= mosi_nx;
      done    <= done_nx;
      timeout <= timeout_nx;
    end
  end

  assign half_end = (cnt == HALF_END);
  assign busy     = (state != IDLE);

  // tx_sr holds the bits still to be sent, next bit at the MSB; mosi itself is a flop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CNT_W'(1);
    bit_cnt_nx = bit_cnt;
    tx_sr_nx   = tx_sr;
    rx_sr_nx   = rx_sr;
    result_nx  = result;
    spi_clk_nx = spi_clk;
    cs_nx      = cs;
    mosi_nx    = mosi;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          tx_sr_nx   = {operands[TX_BITS-2:0], 1'b0};
          mosi_nx    = operands[TX_BITS-1];
          cs_nx      = 1'b0;
          bit_cnt_nx = '0;
          state_nx   = SETUP;
        end
      end
      SETUP: begin
        if (half_end) begin
          cnt_nx     = '0;
          spi_clk_nx = 1'b1;
          state_nx   = TX;
        end
      end
      TX: begin
        if (half_end) begin
          cnt_nx = '0;
          if (spi_clk) begin
            spi_clk_nx = 1'b0;
            mosi_nx    = tx_sr[TX_BITS-1];
            tx_sr_nx   = {tx_sr[TX_BITS-2:0], 1'b0};
          end else if (bit_cnt == TX_LAST) begin
            bit_cnt_nx = '0;
            state_nx   = WAIT_RDY;
          end else begin
            spi_clk_nx = 1'b1;
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      WAIT_RDY: begin
        mosi_nx = 1'b0;
        if (ready_sync) begin
          cnt_nx     = '0;
          bit_cnt_nx = '0;
          spi_clk_nx = 1'b1;
          rx_sr_nx   = {rx_sr[RX_BITS-2:0], miso};
          state_nx   = RX;
        end else if (cnt == WAIT_END) begin
          cnt_nx     = '0;
          cs_nx      = 1'b1;
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      RX: begin
        mosi_nx = 1'b0;
        if (half_end) begin
          cnt_nx = '0;
          if (spi_clk) begin
            spi_clk_nx = 1'b0;
          end else if (bit_cnt == RX_LAST) begin
            cs_nx     = 1'b1;
            result_nx = rx_sr;
            done_nx   = 1'b1;
            state_nx  = FINISH;
          end else begin
            spi_clk_nx = 1'b1;
            rx_sr_nx   = {rx_sr[RX_BITS-2:0], miso};
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      FINISH: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        cs_nx    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: an SPI slave model drives MISO and records
// MOSI, and a monitor measures SCK phases; results are compared per transaction.
module tb_spi_master;
  localparam int CLK_DIV = 2;
  localparam int TX_BITS = 16;
  localparam int RX_BITS = 18;
  localparam int TIMEOUT = 1024;

  logic               hz100;
  logic               rst_n;
  logic               start;
  logic [TX_BITS-1:0] operands;
  logic               spi_clk;
  logic               cs;
  logic               mosi;
  logic               miso = 1'b0;
  logic               ready;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [RX_BITS-1:0] result;

  spi_master #(
    .CLK_DIV(CLK_DIV),
    .TX_BITS(TX_BITS),
    .RX_BITS(RX_BITS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .hz100(hz100),
    .rst_n(rst_n),
    .start(start),
    .operands(operands),
    .spi_clk(spi_clk),
    .cs(cs),
    .mosi(mosi),
    .miso(miso),
    .ready(ready),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .result(result)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge hz100) cyc++;

  // Monitor / slave state, cleared by the driver at the start of each transaction.
  logic [RX_BITS-1:0] slave_word;
  logic [TX_BITS-1:0] tx_cap;
  logic [RX_BITS-1:0] model_result;
  int pulses, falls, hi_run, lo_run, first_gap;
  int bad_hi, bad_lo, bad_mosi, bad_rx_mosi;
  int done_cnt, to_cnt, both_cnt, cs_falls;
  int fall_tx_cyc, rx_rise_cyc, cs_rise_cyc, ready_cyc;
  logic prev_sck = 1'b0;
  logic prev_mosi = 1'b0;
  logic prev_cs = 1'b1;

  task automatic clear_mon();
    pulses = 0; falls = 0; hi_run = 0; lo_run = 0; first_gap = -1;
    bad_hi = 0; bad_lo = 0; bad_mosi = 0; bad_rx_mosi = 0;
    done_cnt = 0; to_cnt = 0; both_cnt = 0; cs_falls = 0;
    fall_tx_cyc = 0; rx_rise_cyc = 0; cs_rise_cyc = 0; ready_cyc = 0;
    tx_cap = '0;
  endtask

  always @(negedge hz100) begin
    if (rst_n) begin
      if (!cs) begin
        if (spi_clk && !prev_sck) begin
          if (pulses == 0) first_gap = lo_run;
          else if (pulses != TX_BITS && lo_run != CLK_DIV) bad_lo++;
          if (pulses == TX_BITS) rx_rise_cyc = cyc;
          if (pulses < TX_BITS) tx_cap = {tx_cap[TX_BITS-2:0], mosi};
          else if (mosi) bad_rx_mosi++;
          pulses++;
          hi_run = 1;
          lo_run = 0;
        end else if (!spi_clk && prev_sck) begin
          if (hi_run != CLK_DIV) bad_hi++;
          falls++;
          if (falls == TX_BITS) fall_tx_cyc = cyc;
          // Mode-0 slave: present the next result bit after each falling edge.
          if (falls >= TX_BITS && falls < TX_BITS + RX_BITS)
            miso = slave_word[RX_BITS-1-(falls-TX_BITS)];
          else
            miso = 1'($urandom_range(0, 1));
          hi_run = 0;
          lo_run = 1;
        end else if (spi_clk) hi_run++;
        else lo_run++;
      end
      if (cs && !prev_cs) begin
        cs_rise_cyc = cyc;
        if (pulses == TX_BITS + RX_BITS && lo_run != CLK_DIV) bad_lo++;
      end
      if (!cs && prev_cs) cs_falls++;
      if (mosi != prev_mosi && spi_clk) bad_mosi++;
      if (done) done_cnt++;
      if (timeout) to_cnt++;
      if (done && timeout) both_cnt++;
    end
    prev_sck  = spi_clk;
    prev_mosi = mosi;
    prev_cs   = cs;
  end

  task automatic finish_txn(input logic [TX_BITS-1:0] op, input logic [RX_BITS-1:0] word,
                            input int ready_delay, input bit expect_to, input bit poke);
    int lim = 6000;
    int waited = 0;
    int lat;
    bit poked = 1'b0;
    while (done_cnt == 0 && to_cnt == 0 && lim > 0) begin
      @(posedge hz100);
      #1;
      lim--;
      start = 1'b0;
      if (poke && !poked && pulses == 4) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (ready_delay > 0 && falls >= TX_BITS) begin
        if (waited == ready_delay) begin
          ready = 1'b1;
          ready_cyc = cyc;
        end
        waited++;
      end
    end
    check("finished_in_time", 32'(lim > 0), 1);
    start = 1'b0;
    repeat (4) @(posedge hz100);
    #1;
    check("no_done_timeout_overlap", both_cnt, 0);
    check("one_cs_fall", cs_falls, 1);
    check("idle_after", 32'(busy), 0);
    check("cs_high_after", 32'(cs), 1);
    check("setup_gap", first_gap, CLK_DIV);
    check("phase_timing", bad_hi + bad_lo + bad_mosi, 0);
    if (expect_to) begin
      lat = cs_rise_cyc - fall_tx_cyc;
      check("to_pulses", pulses, TX_BITS);
      check("to_count", to_cnt, 1);
      check("to_no_done", done_cnt, 0);
      check("to_result_kept", 32'(result), 32'(model_result));
      check("to_latency_ok", 32'(lat >= TIMEOUT && lat <= TIMEOUT + CLK_DIV + 3), 1);
    end else begin
      check("tx_bits", 32'(tx_cap), 32'(op));
      check("rx_mosi_zero", bad_rx_mosi, 0);
      check("pulses", pulses, TX_BITS + RX_BITS);
      check("done_count", done_cnt, 1);
      check("no_timeout", to_cnt, 0);
      check("result", 32'(result), 32'(word));
      model_result = word;
      if (ready_delay > 0) begin
        lat = rx_rise_cyc - ready_cyc;
        check("ready_latency_le3", 32'(lat >= 1 && lat <= 3), 1);
      end
    end
  endtask

  task automatic run_txn(input logic [TX_BITS-1:0] op, input logic [RX_BITS-1:0] word,
                         input int ready_delay, input bit expect_to, input bit poke);
    @(posedge hz100);
    #1;
    clear_mon();
    slave_word = word;
    operands   = op;
    ready      = (ready_delay == 0);
    start      = 1'b1;
    @(posedge hz100);
    #1;
    start = 1'b0;
    check("accepted_busy", 32'(busy), 1);
    check("accepted_cs", 32'(cs), 0);
    check("first_mosi", 32'(mosi), 32'(op[TX_BITS-1]));
    operands = TX_BITS'($urandom);
    finish_txn(op, word, ready_delay, expect_to, poke);
  endtask

  initial begin
    logic [TX_BITS-1:0] op;
    logic [RX_BITS-1:0] w1, w2;
    int lim;
    rst_n = 1'b1; start = 1'b0; operands = '0; ready = 1'b0;
    slave_word = '0; model_result = '0;
    clear_mon();
    #1 rst_n = 1'b0;
    #2;
    check("rst_cs", 32'(cs), 1);
    check("rst_sck", 32'(spi_clk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_result", 32'(result), 0);
    #20 rst_n = 1'b1;

    run_txn(16'hA5C3, 18'h2B3C5, 0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      run_txn(TX_BITS'($urandom), RX_BITS'($urandom),
              (i % 3 == 0) ? 0 : int'($urandom_range(1, 60)), 1'b0, (i % 2 == 1));

    run_txn(TX_BITS'($urandom), RX_BITS'($urandom), 50, 1'b0, 1'b0);
    run_txn(TX_BITS'($urandom), RX_BITS'($urandom), -1, 1'b1, 1'b0);

    // start held high across a whole transaction
    @(posedge hz100);
    #1;
    clear_mon();
    op = TX_BITS'($urandom); w1 = RX_BITS'($urandom); w2 = RX_BITS'($urandom);
    slave_word = w1; operands = op; ready = 1'b1; start = 1'b1;
    lim = 1000;
    while (done_cnt == 0 && lim > 0) begin
      @(posedge hz100);
      #1;
      lim--;
    end
    check("held_done_seen", 32'(lim > 0), 1);
    check("held_result", 32'(result), 32'(w1));
    check("held_one_txn", cs_falls, 1);
    check("held_tx_bits", 32'(tx_cap), 32'(op));
    check("held_idle_after_finish", 32'(busy), 0);
    model_result = w1;
    clear_mon();
    slave_word = w2;
    @(posedge hz100);
    #1;
    check("held_restart_from_idle", 32'(busy), 1);
    start = 1'b0;
    finish_txn(op, w2, 0, 1'b0, 1'b0);

    // reset pulled during the 8th TX bit
    @(posedge hz100);
    #1;
    clear_mon();
    slave_word = RX_BITS'($urandom); operands = '1; ready = 1'b1; start = 1'b1;
    @(posedge hz100);
    #1;
    start = 1'b0;
    lim = 500;
    while (pulses < 8 && lim > 0) begin
      @(posedge hz100);
      #1;
      lim--;
    end
    check("reached_bit8", pulses, 8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs", 32'(cs), 1);
    check("midrst_sck", 32'(spi_clk), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_mosi", 32'(mosi), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", 32'(result), 0);
    model_result = '0;
    repeat (2) @(posedge hz100);
    #3 rst_n = 1'b1;
    run_txn(16'h0001, RX_BITS'($urandom), 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
